// File: rtl/xadac_pkg.sv
// xadac_pkg: shared xadac datapath types plus vector-load FSM state and beat-count helper
package xadac_pkg;
  localparam int VectorWidth = 128;
  localparam int RegIdWidth = 5;
  typedef logic [RegIdWidth-1:0] RegIdT;
  typedef logic [VectorWidth-1:0] VectorT;
  typedef logic [VectorWidth/8-1:0] BeT;
  typedef enum logic [1:0] {VL_IDLE, VL_ISSUE, VL_WAIT, VL_WRITE} VLoadStateT;
  function automatic int BeatsPerVector(input int bus_width);
    return VectorWidth / bus_width;
  endfunction
endpackage

// File: rtl/xadac_beat_buffer.sv
// xadac_beat_buffer: assembles in-order beat responses into the active beat slots of one vector
module xadac_beat_buffer #(
  parameter int BusWidth = 32,
  parameter int Beats = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_clr,
  input  logic [Beats-1:0]          i_mask,
  input  logic                      i_we,
  input  logic [BusWidth-1:0]       i_data,
  output logic [Beats*BusWidth-1:0] o_data,
  output logic                      o_cap
);
  logic [Beats*BusWidth-1:0] r_data;
  logic [Beats-1:0] r_pend;
  logic [Beats-1:0] w_sel;
  logic [Beats-1:0] w_left;
  // the lowest still-unfilled active beat is the one the next response belongs to
  always_comb begin
    w_sel = r_pend & (~r_pend + 1'b1);
    w_left = i_we ? (r_pend & ~w_sel) : r_pend;
  end
  assign o_cap = w_left == '0;
  assign o_data = r_data;
  // clear loads the set of beats still owed; each response fills and retires one slot
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data <= '0;
      r_pend <= '0;
    end else if (i_clr) begin
      r_data <= '0;
      r_pend <= i_mask;
    end else if (i_we) begin
      for (int i = 0; i < Beats; i++)
        if (w_sel[i]) r_data[i*BusWidth +: BusWidth] <= i_data;
      r_pend <= w_left;
    end
  end
endmodule

// File: rtl/xadac_vload.sv
// xadac_vload: fetches one masked vector as bus beats and writes it to the VRF write port
module xadac_vload
  import xadac_pkg::*;
#(
  parameter int BusWidth = 32,
  parameter int AddrWidth = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [AddrWidth-1:0] req_addr,
  input  RegIdT                req_vd,
  input  BeT                   req_be,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [AddrWidth-1:0] mem_req_addr,
  input  logic                 mem_rsp_valid,
  input  logic [BusWidth-1:0]  mem_rsp_data,
  input  logic                 mem_rsp_err,
  output RegIdT                vrf_wid,
  output VectorT               vrf_wdata,
  output BeT                   vrf_wbe,
  output logic                 vrf_we,
  output logic                 done_valid,
  output logic                 done_err,
  output logic                 busy
);
  localparam int Beats = BeatsPerVector(BusWidth);
  localparam int BB = BusWidth / 8;
  localparam int OW = $clog2(Beats + 1);
  VLoadStateT r_state;
  logic [AddrWidth-1:0] r_base;
  RegIdT r_vd;
  BeT r_be;
  logic [Beats-1:0] r_ipend;
  logic [OW-1:0] r_out;
  logic r_err;
  logic [Beats-1:0] w_act;
  logic [Beats-1:0] w_isel;
  logic [Beats-1:0] w_irem;
  logic [AddrWidth-1:0] w_maddr;
  logic w_hs;
  logic w_rsp;
  logic w_cap;
  logic w_accept;
  VectorT w_buf;
  for (genvar b = 0; b < Beats; b++) begin : g_act
    assign w_act[b] = |req_be[b*BB +: BB];
  end
  // next beat to issue is the lowest active beat not yet accepted by memory
  always_comb begin
    w_isel = r_ipend & (~r_ipend + 1'b1);
    w_irem = r_ipend & ~w_isel;
    w_maddr = r_base;
    for (int i = 0; i < Beats; i++)
      if (w_isel[i]) w_maddr = r_base + AddrWidth'(i * BB);
  end
  assign w_accept = (r_state == VL_IDLE) && req_valid;
  assign w_hs = (r_state == VL_ISSUE) && mem_req_ready;
  assign w_rsp = mem_rsp_valid && (r_out != '0);
  assign mem_req_valid = r_state == VL_ISSUE;
  assign mem_req_addr = w_maddr;
  assign req_ready = r_state == VL_IDLE;
  assign busy = r_state != VL_IDLE;
  assign done_valid = r_state == VL_WRITE;
  assign done_err = done_valid && r_err;
  assign vrf_we = done_valid && !r_err && (r_be != '0);
  assign vrf_wid = done_valid ? r_vd : '0;
  assign vrf_wbe = done_valid ? r_be : '0;
  assign vrf_wdata = done_valid ? w_buf : '0;
  xadac_beat_buffer #(.BusWidth(BusWidth), .Beats(Beats)) u_buf (
    .clk(clk),
    .rstn(rstn),
    .i_clr(w_accept),
    .i_mask(w_act),
    .i_we(w_rsp),
    .i_data(mem_rsp_data),
    .o_data(w_buf),
    .o_cap(w_cap)
  );
  // outstanding beats: +1 per issued beat, -1 per accepted response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_out <= '0;
    else r_out <= r_out + OW'(w_hs) - OW'(w_rsp);
  end
  // control FSM; the error flag accumulates bus errors for the current load
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= VL_IDLE;
      r_base <= '0;
      r_vd <= '0;
      r_be <= '0;
      r_ipend <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept ? 1'b0 : (r_err | (w_rsp & mem_rsp_err));
      case (r_state)
        VL_IDLE: if (req_valid) begin
          r_base <= req_addr & ~AddrWidth'(BB - 1);
          r_vd <= req_vd;
          r_be <= req_be;
          r_ipend <= w_act;
          r_state <= (req_be == '0) ? VL_WRITE : VL_ISSUE;
        end
        VL_ISSUE: if (w_hs) begin
          r_ipend <= w_irem;
          r_state <= (w_irem == '0) ? VL_WAIT : VL_ISSUE;
        end
        VL_WAIT: r_state <= w_cap ? VL_WRITE : VL_WAIT;
        default: r_state <= VL_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xadac_vload.sv
// tb_xadac_vload: directed vectors against a transaction-level model of the vector load
module tb_xadac_vload;
  import xadac_pkg::*;
  logic clk = 0;
  logic rstn = 0;
  logic req_valid = 0;
  logic req_ready;
  logic [31:0] req_addr = 0;
  RegIdT req_vd = 0;
  BeT req_be = 0;
  logic mem_req_valid;
  logic mem_req_ready = 1;
  logic [31:0] mem_req_addr;
  logic mem_rsp_valid = 0;
  logic [31:0] mem_rsp_data = 0;
  logic mem_rsp_err = 0;
  RegIdT vrf_wid;
  VectorT vrf_wdata;
  BeT vrf_wbe;
  logic vrf_we;
  logic done_valid;
  logic done_err;
  logic busy;

  int tests = 0;
  int failed = 0;

  xadac_vload #(.BusWidth(32), .AddrWidth(32)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_vd(req_vd), .req_be(req_be),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .vrf_wid(vrf_wid), .vrf_wdata(vrf_wdata), .vrf_wbe(vrf_wbe), .vrf_we(vrf_we),
    .done_valid(done_valid), .done_err(done_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [3:0] n;
    n = a[5:2] + 4'd1;
    return {8{n}};
  endfunction

  // memory model: in-order responses one cycle after acceptance, optional hold budget
  logic [31:0] q_addr[$];
  int rsp_limit = 1 << 30;
  int ready_mode = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  initial begin
    int cyc;
    logic hs;
    logic [31:0] ha;
    logic [31:0] a;
    cyc = 0;
    forever begin
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready;
      ha = mem_req_addr;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) q_addr.push_back(ha);
      chk("outstanding_le_4", 128'(q_addr.size() <= 4), 128'd1);
      if (q_addr.size() > 0 && rsp_limit > 0) begin
        a = q_addr.pop_front();
        rsp_limit--;
        mem_rsp_valid = 1;
        mem_rsp_data = mem_word(a);
        mem_rsp_err = (a == err_addr);
      end else begin
        mem_rsp_valid = 0;
        mem_rsp_data = 0;
        mem_rsp_err = 0;
      end
      mem_req_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    end
  end

  // reference model of the pending load, built from the request alone
  logic [31:0] exp_q[$];
  logic [31:0] iss_log[$];
  VectorT exp_data;
  RegIdT exp_vd;
  BeT exp_be;
  logic exp_err;
  logic exp_we;
  logic armed = 0;
  VectorT last_wdata;
  logic last_we;
  logic last_err;

  function automatic void model_load(input logic [31:0] addr, input RegIdT vd, input BeT be);
    logic [31:0] a;
    exp_q.delete();
    iss_log.delete();
    exp_data = '0;
    exp_err = 0;
    for (int i = 0; i < 4; i++)
      if (be[4*i +: 4] != 4'h0) begin
        a = {addr[31:2], 2'b00} + 32'(4 * i);
        exp_q.push_back(a);
        exp_data[32*i +: 32] = mem_word(a);
        if (a == err_addr) exp_err = 1;
      end
    exp_vd = vd;
    exp_be = be;
    exp_we = !exp_err && (be != '0);
    armed = 1;
  endfunction

  // per-cycle compare of every meaningful output against the model
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      chk("req_ready_vs_busy", 128'(req_ready), 128'(!busy));
      if (mem_req_valid) begin
        chk("mreq_expected", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) begin
          chk("mreq_addr", 128'(mem_req_addr), 128'(exp_q[0]));
          if (mem_req_ready) begin
            iss_log.push_back(mem_req_addr);
            void'(exp_q.pop_front());
          end
        end
      end
      if (done_valid) begin
        chk("done_expected", 128'(armed), 128'd1);
        chk("all_beats_issued", 128'(exp_q.size()), 128'd0);
        chk("vrf_wid", 128'(vrf_wid), 128'(exp_vd));
        chk("vrf_wdata", vrf_wdata, exp_data);
        chk("vrf_wbe", 128'(vrf_wbe), 128'(exp_be));
        chk("vrf_we", 128'(vrf_we), 128'(exp_we));
        chk("done_err", 128'(done_err), 128'(exp_err));
        last_wdata = vrf_wdata;
        last_we = vrf_we;
        last_err = done_err;
        armed = 0;
      end else begin
        chk("vrf_we_idle", 128'(vrf_we), 128'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_req_valid"}, 128'(mem_req_valid), 128'd0);
    chk({tag, "_vrf_we"}, 128'(vrf_we), 128'd0);
    chk({tag, "_vrf_wbe"}, 128'(vrf_wbe), 128'd0);
    chk({tag, "_vrf_wid"}, 128'(vrf_wid), 128'd0);
    chk({tag, "_vrf_wdata"}, vrf_wdata, 128'd0);
    chk({tag, "_done_valid"}, 128'(done_valid), 128'd0);
    chk({tag, "_done_err"}, 128'(done_err), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_req_ready"}, 128'(req_ready), 128'd1);
  endtask

  task automatic start_req(input logic [31:0] addr, input RegIdT vd, input BeT be);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("req_ready_wait", 128'(req_ready), 128'd1);
    model_load(addr, vd, be);
    req_valid = 1;
    req_addr = addr;
    req_vd = vd;
    req_be = be;
    @(posedge clk);
    #1;
    req_valid = 0;
  endtask

  task automatic do_load(input logic [31:0] addr, input RegIdT vd, input BeT be, output int lat);
    start_req(addr, vd, be);
    lat = 1;
    while (!done_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("done_timeout", 128'(lat < 200), 128'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1;
    @(posedge clk);
    #1;

    // full load, zero-wait memory
    do_load(32'h1000, 5'd5, 16'hFFFF, lat);
    chk("full_latency", 128'(lat), 128'd6);
    chk("full_model_pin", exp_data, 128'h44444444_33333333_22222222_11111111);
    chk("full_wdata", last_wdata, 128'h44444444_33333333_22222222_11111111);
    chk("full_we", 128'(last_we), 128'd1);
    chk("full_err", 128'(last_err), 128'd0);
    chk("full_issued", 128'(iss_log.size()), 128'd4);

    // sparse mask with misaligned base
    do_load(32'h2003, 5'd3, 16'h0F0F, lat);
    chk("sparse_issued", 128'(iss_log.size()), 128'd2);
    if (iss_log.size() == 2) begin
      chk("sparse_addr0", 128'(iss_log[0]), 128'h2000);
      chk("sparse_addr1", 128'(iss_log[1]), 128'h2008);
    end
    chk("sparse_wdata", last_wdata, 128'h00000000_33333333_00000000_11111111);

    // bus error on beat 2
    err_addr = 32'h1008;
    do_load(32'h1000, 5'd7, 16'hFFFF, lat);
    chk("err_issued", 128'(iss_log.size()), 128'd4);
    chk("err_we", 128'(last_we), 128'd0);
    chk("err_flag", 128'(last_err), 128'd1);
    err_addr = 32'hFFFF_FFFF;

    // backpressure with responses overlapping issue
    ready_mode = 1;
    do_load(32'h1000, 5'd9, 16'hFFFF, lat);
    chk("bp_issued", 128'(iss_log.size()), 128'd4);
    chk("bp_wdata", last_wdata, 128'h44444444_33333333_22222222_11111111);
    do_load(32'h3000, 5'd10, 16'hF0F0, lat);
    chk("bp_sparse_wdata", last_wdata, 128'h44444444_00000000_22222222_00000000);
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // empty mask
    do_load(32'h4000, 5'd1, 16'h0000, lat);
    chk("empty_latency", 128'(lat), 128'd1);
    chk("empty_issued", 128'(iss_log.size()), 128'd0);
    chk("empty_we", 128'(last_we), 128'd0);
    chk("empty_err", 128'(last_err), 128'd0);

    // reset while waiting on two outstanding beats
    rsp_limit = 2;
    start_req(32'h1000, 5'd12, 16'hFFFF);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_busy", 128'(busy), 128'd1);
    chk("mid_pending", 128'(q_addr.size()), 128'd2);
    #2;
    rstn = 0;
    armed = 0;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    rsp_limit = 1 << 30;
    n = 0;
    while (q_addr.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("stale_drained", 128'(q_addr.size()), 128'd0);
    chk("stale_idle", 128'(busy), 128'd0);
    do_load(32'h1000, 5'd6, 16'hFFFF, lat);
    chk("post_rst_latency", 128'(lat), 128'd6);
    chk("post_rst_wdata", last_wdata, 128'h44444444_33333333_22222222_11111111);
    chk("post_rst_we", 128'(last_we), 128'd1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
